// File: rtl/ifetcher_pkg.sv
// Shared constants and types for the instruction fetch front end.
package ifetcher_pkg;

  typedef enum logic [1:0] {
    ST_REQ,        // byte request outstanding on the memory port
    ST_WAITB,      // granted, waiting for the byte
    ST_PRESENT,    // instruction presented to the decoder
    ST_WAIT_JALR   // fetch parked until the decoder redirects
  } fetch_state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] RVC_Q1     = 2'b01;
  localparam logic [1:0] RVC_Q2     = 2'b10;
  localparam logic [1:0] RVC_NONE   = 2'b11;

  localparam logic [2:0] C_F3_JAL   = 3'b001;
  localparam logic [2:0] C_F3_JR    = 3'b100;
  localparam logic [2:0] C_F3_J     = 3'b101;
  localparam logic [2:0] C_F3_BEQZ  = 3'b110;
  localparam logic [2:0] C_F3_BNEZ  = 3'b111;

  // Little-endian byte insertion into the assembly word.
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    unique case (idx)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ifetcher_predecode.sv
// Combinational predecode: instruction length, JALR detection and static
// next-PC prediction (jumps taken, backward branches taken).
module ifetch_predecode
  import ifetcher_pkg::*;
(
  input  logic [31:0] ins_i,
  input  logic [31:0] pc_i,
  output logic        is16_o,
  output logic        is_jalr_o,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] imm_cj;
  logic [31:0] imm_cb;
  logic [31:0] off;
  logic [2:0]  f3c;

  // Immediate extraction for the four predicted control-flow forms.
  always_comb begin
    imm_j  = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
    imm_b  = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
    imm_cj = {{20{ins_i[12]}}, ins_i[12], ins_i[8], ins_i[10:9], ins_i[6], ins_i[7],
              ins_i[2], ins_i[11], ins_i[5:3], 1'b0};
    imm_cb = {{23{ins_i[12]}}, ins_i[12], ins_i[6:5], ins_i[2], ins_i[11:10],
              ins_i[4:3], 1'b0};
    f3c    = ins_i[15:13];
  end

  // Classification and target selection; not-taken falls through by length.
  always_comb begin
    is16_o    = (ins_i[1:0] != RVC_NONE);
    is_jalr_o = 1'b0;
    taken_o   = 1'b0;
    off       = is16_o ? 32'd2 : 32'd4;
    if (is16_o) begin
      if (ins_i[1:0] == RVC_Q1 && (f3c == C_F3_JAL || f3c == C_F3_J)) begin
        taken_o = 1'b1;
        off     = imm_cj;
      end else if (ins_i[1:0] == RVC_Q1 && (f3c == C_F3_BEQZ || f3c == C_F3_BNEZ)) begin
        if (ins_i[12]) begin
          taken_o = 1'b1;
          off     = imm_cb;
        end
      end else if (ins_i[1:0] == RVC_Q2 && f3c == C_F3_JR &&
                   ins_i[11:7] != 5'd0 && ins_i[6:2] == 5'd0) begin
        is_jalr_o = 1'b1;
      end
    end else begin
      if (ins_i[6:0] == OPC_JAL) begin
        taken_o = 1'b1;
        off     = imm_j;
      end else if (ins_i[6:0] == OPC_BRANCH) begin
        if (ins_i[31]) begin
          taken_o = 1'b1;
          off     = imm_b;
        end
      end else if (ins_i[6:0] == OPC_JALR) begin
        is_jalr_o = 1'b1;
      end
    end
    target_o = pc_i + off;
  end

endmodule

// File: rtl/ifetcher.sv
// Instruction fetch front end: byte-serial fetch, RV32I/RVC assembly,
// static prediction, decoder handshake and redirect handling.
module ifetcher
  import ifetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] predict_nxt_pc,
  input  logic        stall,
  input  logic        clear,
  input  logic [31:0] new_addr,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_addr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  buf_q, buf_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         out_q, out_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         rdy_q, rdy_d;
  logic [31:0]  ins_q, ins_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pnpc_q, pnpc_d;
  logic         jalr_q, jalr_d;

  logic         cap;
  logic [31:0]  buf_c;
  logic [2:0]   cnt_c;
  logic [31:0]  asm_ins;
  logic         done;
  logic         redirect;
  logic [31:0]  redir_addr;

  logic         pd_is16;
  logic         pd_is_jalr;
  logic         pd_taken;
  logic [31:0]  pd_target;

  // Byte capture view: the returning byte is merged even while frozen.
  always_comb begin
    cap        = mem_rvalid && out_q;
    buf_c      = cap ? put_byte(buf_q, cnt_q[1:0], mem_rdata) : buf_q;
    cnt_c      = cnt_q + 3'(cap);
    asm_ins    = (cnt_c == 3'd2) ? {16'h0, buf_c[15:0]} : buf_c;
    done       = (cnt_c == 3'd4) || (cnt_c == 3'd2 && pd_is16);
    redirect   = rob_flush || clear;
    redir_addr = rob_flush ? rob_flush_addr : new_addr;
  end

  ifetch_predecode u_predecode (
    .ins_i     (asm_ins),
    .pc_i      (fpc_q),
    .is16_o    (pd_is16),
    .is_jalr_o (pd_is_jalr),
    .taken_o   (pd_taken),
    .target_o  (pd_target)
  );

  // Next-state logic for the fetch FSM, handshake and presentation registers.
  // A byte captured while rdy_in was low clears out_q; WAITB then proceeds
  // on !out_q so the frozen cycle does not lose the byte.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    buf_d   = buf_c;
    cnt_d   = cnt_c;
    out_d   = out_q && !cap;
    req_d   = req_q;
    addr_d  = addr_q;
    rdy_d   = rdy_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    pnpc_d  = pnpc_q;
    jalr_d  = jalr_q;
    if (rdy_in) begin
      if (redirect) begin
        state_d = ST_REQ;
        fpc_d   = redir_addr;
        addr_d  = redir_addr;
        req_d   = 1'b1;
        rdy_d   = 1'b0;
        buf_d   = '0;
        cnt_d   = '0;
        out_d   = 1'b0;
      end else begin
        unique case (state_q)
          ST_REQ: begin
            if (!req_q) begin
              req_d  = 1'b1;
              addr_d = fpc_q;
            end else if (mem_gnt) begin
              req_d   = 1'b0;
              out_d   = 1'b1;
              state_d = ST_WAITB;
            end
          end
          ST_WAITB: begin
            if (cap || !out_q) begin
              if (done) begin
                state_d = ST_PRESENT;
                rdy_d   = 1'b1;
                ins_d   = asm_ins;
                pc_d    = {fpc_q[31:1], pd_taken};
                pnpc_d  = pd_target;
                jalr_d  = pd_is_jalr;
              end else begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = addr_q + 32'd1;
              end
            end
          end
          ST_PRESENT: begin
            if (!stall) begin
              rdy_d = 1'b0;
              fpc_d = pnpc_q;
              buf_d = '0;
              cnt_d = '0;
              if (jalr_q) begin
                state_d = ST_WAIT_JALR;
              end else begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = pnpc_q;
              end
            end
          end
          ST_WAIT_JALR: ;
          default: ;
        endcase
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_REQ;
      fpc_q   <= RESET_PC;
      buf_q   <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      ins_q   <= '0;
      pc_q    <= '0;
      pnpc_q  <= '0;
      jalr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      pnpc_q  <= pnpc_d;
      jalr_q  <= jalr_d;
    end
  end

  assign mem_req        = req_q;
  assign mem_addr       = addr_q;
  assign ins_ready      = rdy_q;
  assign ins            = ins_q;
  assign pc             = pc_q;
  assign predict_nxt_pc = pnpc_q;

endmodule

// File: tb/tb_ifetcher.sv
// Self-checking bench for ifetcher: directed scenarios followed by random
// stall/redirect/grant/freeze traffic against a program-order reference.
module tb_ifetcher;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] predict_nxt_pc;
  logic        stall;
  logic        clear;
  logic [31:0] new_addr;
  logic        rob_flush;
  logic [31:0] rob_flush_addr;

  ifetcher #(.RESET_PC(32'h0)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .pc             (pc),
    .predict_nxt_pc (predict_nxt_pc),
    .stall          (stall),
    .clear          (clear),
    .new_addr       (new_addr),
    .rob_flush      (rob_flush),
    .rob_flush_addr (rob_flush_addr)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [7:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  // controls applied by step()
  bit          c_rdy = 1, c_stall = 1, c_clear = 0, c_flush = 0;
  logic [31:0] c_caddr = '0, c_faddr = '0;
  int          gnt_prob = 100;

  // reference model: program-order fetch pointer and presented instruction
  logic [31:0] m_fpc = 32'h0;
  int          m_nbytes = 0;
  bit          m_wait = 0;
  logic [31:0] m_ins, m_pc, m_tgt;
  bit          m_jr;
  bit          prev_ready = 0;
  bit          pend = 0;
  logic [7:0]  pend_d;
  bit          last_gnt = 0;
  logic [31:0] last_gnt_addr;
  int          idle = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd8(input logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  task automatic put32(input logic [31:0] a, input logic [31:0] w);
    for (int unsigned k = 0; k < 4; k++) mem[(a + k) & 32'hFFF] = w[8*k +: 8];
  endtask

  // Expected instruction at address a, with length and static prediction.
  function automatic void ref_decode(input logic [31:0] a, output logic [31:0] e_ins,
                                     output int len, output bit tk,
                                     output logic [31:0] tgt, output bit jr);
    logic [15:0] lo;
    logic [2:0]  f3;
    int          imm;
    lo  = {rd8(a + 1), rd8(a)};
    tk  = 0;
    jr  = 0;
    imm = 0;
    if (lo[1:0] != 2'b11) begin
      len   = 2;
      e_ins = {16'h0, lo};
      f3    = lo[15:13];
      if (lo[1:0] == 2'b01 && (f3 == 3'd1 || f3 == 3'd5)) begin
        tk  = 1;
        imm = (lo[12] ? -2048 : 0) + int'(lo[8]) * 1024 + int'(lo[10:9]) * 256 +
              int'(lo[6]) * 128 + int'(lo[7]) * 64 + int'(lo[2]) * 32 +
              int'(lo[11]) * 16 + int'(lo[5:3]) * 2;
      end else if (lo[1:0] == 2'b01 && f3 >= 3'd6) begin
        imm = (lo[12] ? -256 : 0) + int'(lo[6:5]) * 64 + int'(lo[2]) * 32 +
              int'(lo[11:10]) * 8 + int'(lo[4:3]) * 2;
        tk  = (imm < 0);
      end else if (lo[1:0] == 2'b10 && f3 == 3'd4 && lo[11:7] != 5'd0 && lo[6:2] == 5'd0) begin
        jr = 1;
      end
    end else begin
      len   = 4;
      e_ins = {rd8(a + 3), rd8(a + 2), lo};
      case (e_ins[6:0])
        7'h6F: begin
          tk  = 1;
          imm = (e_ins[31] ? -(1 << 20) : 0) + int'(e_ins[19:12]) * 4096 +
                int'(e_ins[20]) * 2048 + int'(e_ins[30:21]) * 2;
        end
        7'h63: begin
          imm = (e_ins[31] ? -4096 : 0) + int'(e_ins[7]) * 2048 +
                int'(e_ins[30:25]) * 32 + int'(e_ins[11:8]) * 2;
          tk  = (imm < 0);
        end
        7'h67: jr = 1;
        default: ;
      endcase
    end
    tgt = tk ? a + 32'(imm) : a + 32'(len);
  endfunction

  // One clock: check outputs at the falling edge, drive inputs, advance model.
  task automatic step();
    logic [31:0] e_ins, e_tgt;
    int          e_len;
    bit          e_tk, e_jr;
    @(negedge clk_in);
    idle++;
    if (ins_ready && !prev_ready) begin
      ref_decode(m_fpc, e_ins, e_len, e_tk, e_tgt, e_jr);
      m_ins = e_ins;
      m_pc  = {m_fpc[31:1], e_tk};
      m_tgt = e_tgt;
      m_jr  = e_jr;
      check_eq("ins", ins, m_ins);
      check_eq("pc", pc, m_pc);
      check_eq("pnpc", predict_nxt_pc, m_tgt);
      check_eq("nbytes", 32'(m_nbytes), 32'(e_len));
      idle = 0;
    end else if (ins_ready) begin
      check_eq("hold_ins", ins, m_ins);
      check_eq("hold_pc", pc, m_pc);
      check_eq("hold_pnpc", predict_nxt_pc, m_tgt);
      check_eq("hold_noreq", 32'(mem_req), 32'd0);
    end
    if (m_wait) check_eq("jalr_noreq", 32'(mem_req), 32'd0);

    rdy_in         = c_rdy;
    stall          = c_stall;
    clear          = c_clear;
    new_addr       = c_caddr;
    rob_flush      = c_flush;
    rob_flush_addr = c_faddr;
    mem_rvalid     = pend;
    mem_rdata      = pend ? pend_d : 8'($urandom);
    pend           = 0;
    mem_gnt        = 0;
    last_gnt       = 0;
    if (mem_req && c_rdy && ($urandom_range(99) < gnt_prob)) begin
      mem_gnt       = 1;
      last_gnt      = 1;
      last_gnt_addr = mem_addr;
      check_eq("gnt_addr", mem_addr, m_fpc + 32'(m_nbytes));
      m_nbytes++;
      pend   = 1;
      pend_d = rd8(mem_addr);
    end

    if (c_rdy) begin
      if (c_flush || c_clear) begin
        m_fpc    = c_flush ? c_faddr : c_caddr;
        m_nbytes = 0;
        m_wait   = 0;
      end else if (ins_ready && !c_stall) begin
        m_nbytes = 0;
        if (m_jr) m_wait = 1;
        else      m_fpc  = m_tgt;
      end
    end
    prev_ready = ins_ready;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200; i++) begin
      step();
      if (ins_ready) return;
    end
    check_eq(tag, 32'(ins_ready), 32'd1);
  endtask

  task automatic redirect_clear(input logic [31:0] a);
    c_clear = 1;
    c_caddr = a;
    step();
    c_clear = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] h;
    logic [4:0]  opl [5];
    opl = '{5'b11011, 5'b11000, 5'b11001, 5'b00100, 5'b01101};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    put32(32'h000, 32'h00500093);          // addi x1,x0,5
    mem[4] = 8'h05; mem[5] = 8'h45;        // c.li a0,1
    put32(32'h018, 32'h00000013);          // nop
    put32(32'h020, 32'hFE000CE3);          // beq x0,x0,-8
    put32(32'h040, 32'h00008067);          // jalr x0,0(x1)
    put32(32'h100, 32'h00A00513);          // addi a0,x0,10
    put32(32'h200, 32'h01400593);          // addi a1,x0,20

    rst_in = 0; rdy_in = 0; stall = 0; clear = 0; new_addr = '0;
    rob_flush = 0; rob_flush_addr = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    #12;
    check_eq("rst_ready", 32'(ins_ready), 32'd0);
    check_eq("rst_ins", ins, 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pnpc", predict_nxt_pc, 32'h0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_addr", mem_addr, 32'h0);
    @(negedge clk_in);
    rst_in = 1;

    // first fetch after reset
    wait_ready("t1_tmo");
    check_eq("t1_ins", ins, 32'h00500093);
    check_eq("t1_pc", pc, 32'h0);
    check_eq("t1_pnpc", predict_nxt_pc, 32'h4);

    // compressed instruction at 4
    c_stall = 0; step(); c_stall = 1;
    wait_ready("t2_tmo");
    check_eq("t2_ins", ins, 32'h00004505);
    check_eq("t2_pnpc", predict_nxt_pc, 32'h6);

    // backward branch, then its predicted target
    redirect_clear(32'h20);
    wait_ready("t3_tmo");
    check_eq("t3_pc", pc, 32'h21);
    check_eq("t3_pnpc", predict_nxt_pc, 32'h18);
    c_stall = 0; step(); c_stall = 1;
    wait_ready("t3b_tmo");
    check_eq("t3_next_pc", pc, 32'h18);

    // forward branch
    put32(32'h020, 32'h00000863);          // beq x0,x0,+16
    redirect_clear(32'h20);
    wait_ready("t4_tmo");
    check_eq("t4_pc", pc, 32'h20);
    check_eq("t4_pnpc", predict_nxt_pc, 32'h24);

    // stall three cycles, then release
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_ins", ins, 32'h00000863);
      check_eq("stall_req", 32'(mem_req), 32'd0);
    end
    c_stall = 0; step(); c_stall = 1; step();
    check_eq("stall_fall", 32'(ins_ready), 32'd0);

    // JALR parks the fetcher until clear
    redirect_clear(32'h40);
    wait_ready("t5_tmo");
    c_stall = 0; step(); c_stall = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("jalr_park", 32'(mem_req), 32'd0);
    end
    redirect_clear(32'h100);
    step();
    check_eq("jalr_req", 32'(mem_req), 32'd1);
    check_eq("jalr_addr", mem_addr, 32'h100);

    // flush the cycle after the grant of byte 2
    for (int i = 0; i < 60; i++) begin
      step();
      if (last_gnt && last_gnt_addr == 32'h102) break;
    end
    check_eq("t6_gnt2", last_gnt_addr, 32'h102);
    c_flush = 1; c_faddr = 32'h200; step(); c_flush = 0;
    step();
    check_eq("flush_req", 32'(mem_req), 32'd1);
    check_eq("flush_addr", mem_addr, 32'h200);
    wait_ready("t6_tmo");
    check_eq("flush_ins", ins, 32'h01400593);

    // random program image; fetcher is parked in PRESENT while it is written
    for (int a = 0; a < 4096; a += 2) begin
      h = $urandom;
      if ($urandom_range(1) == 1) begin
        h[1:0] = 2'b11;
        h[6:2] = opl[$urandom_range(4)];
      end
      mem[a]     = h[7:0];
      mem[a + 1] = h[15:8];
    end

    gnt_prob = 60;
    for (int i = 0; i < 4000; i++) begin
      c_rdy   = ($urandom_range(9) != 0);
      c_stall = ($urandom_range(2) == 0);
      c_flush = ($urandom_range(59) == 0);
      c_faddr = $urandom & 32'h0000_0FFE;
      c_clear = (m_wait && $urandom_range(3) == 0) || ($urandom_range(79) == 0);
      c_caddr = $urandom & 32'h0000_0FFE;
      step();
      if (idle > 400) begin
        check_eq("watchdog_idle", 32'(idle), 32'd0);
        break;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
